divider_17_9bit: RTL
====================

DIVIDER_17_9BIT -- requirements
Module: divider_17_9bit

Interface
REQ-001 The block SHALL expose parameter N, default 17, dividend and quotient width.
REQ-002 The block SHALL expose parameter M, default 9, divisor and remainder width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to begin a division.
REQ-006 The block SHALL have port dividend, input, N, signed two's-complement dividend.
REQ-007 The block SHALL have port divisor, input, M, signed two's-complement divisor.
REQ-008 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-009 The block SHALL have port data_valid, output, 1, one-cycle result strobe.
REQ-010 The block SHALL have port quotient, output, N, signed quotient.
REQ-011 The block SHALL have port remainder, output, M, signed remainder.
REQ-012 The block SHALL have port div_by_zero, output, 1, error flag for divisor == 0.
REQ-013 The block SHALL have port overflow, output, 1, error flag for an unrepresentable quotient.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-015 In IDLE, start == 1 at an edge SHALL latch dividend and divisor, record the operand signs, load the magnitudes, clear iteration count and partial remainder, and move to BUSY.
REQ-016 In BUSY, each cycle SHALL perform one restoring shift-subtract step: shift the partial remainder left and bring in the next dividend MSB; trial-subtract |divisor|; if non-negative, keep the difference and shift in quotient bit 1, else restore and shift in 0.
REQ-017 BUSY SHALL last exactly N (17) cycles, then move to DONE.
REQ-018 In DONE, the block SHALL apply signs (quotient negative iff operand signs differ; remainder takes the dividend sign), register quotient and remainder, and set data_valid = 1 for exactly one cycle before returning to IDLE.
REQ-019 Latency SHALL be fixed: data_valid SHALL assert at the 18th edge after the edge that sampled start, regardless of operand values, including error cases.
REQ-020 busy SHALL be 1 in BUSY and DONE, and 0 in IDLE.
REQ-021 start SHALL be ignored in BUSY and DONE; a start held high through DONE SHALL begin a new division at the first IDLE edge.
REQ-022 quotient, remainder and the error flags SHALL hold their values until the next DONE.
REQ-023 Rounding SHALL truncate toward zero, so that dividend == quotient*divisor + remainder and |remainder| < |divisor|.
REQ-024 Divisor == 0 SHALL set div_by_zero = 1 and remainder = 0; quotient SHALL be 17'h0FFFF if dividend >= 0, else 17'h10001.
REQ-025 Dividend == 17'h10000 with divisor == 9'h1FF SHALL set overflow = 1, quotient = 17'h0FFFF and remainder = 0.
REQ-026 A divisor of 9'h100 (-256) SHALL be handled correctly; the magnitude path SHALL be at least M+1 bits wide.

Reset
REQ-027 rst_n low SHALL, asynchronously, force IDLE and clear busy, data_valid, quotient, remainder, div_by_zero, overflow and all internal registers to 0.
REQ-028 Reset mid-operation SHALL abort the division with no data_valid pulse; the first start after rst_n rises SHALL complete normally.

Structure
REQ-029 The widths (17, 9), the state encoding and the saturation constants SHALL live in shared package fft_arith_pkg.
REQ-030 The trial subtraction SHALL instantiate the existing N_bit_adder sub-module with N=10, adding the two's complement of |divisor|; no other sub-modules SHALL be used.

Verification
REQ-031 100 / 7 -> after 18 edges, quotient = 14 and remainder = 2, with a single-cycle data_valid and both flags 0.
REQ-032 -100 / 7 -> quotient = 17'h1FFF2 (-14) and remainder = 9'h1FE (-2); 1000 / -3 -> quotient = 17'h1FEB3 (-333) and remainder = 1.
REQ-033 5 / 0 -> div_by_zero = 1, quotient = 17'h0FFFF, remainder = 0; -5 / 0 -> quotient = 17'h10001.
REQ-034 17'h10000 / 9'h1FF -> overflow = 1 and quotient = 17'h0FFFF; 17'h10000 / 9'h100 -> quotient = 256, remainder = 0, overflow = 0.
REQ-035 A start pulse in BUSY with different operands SHALL be ignored: the original result is produced and there is only one data_valid pulse.
REQ-036 rst_n pulsed low at BUSY cycle 8 -> outputs are 0 with no data_valid; a following 100 / 7 SHALL return 14 and 2.

Source files
------------

// File: rtl/fft_arith_pkg.sv
// Shared arithmetic definitions: divider widths, FSM encoding and saturation constants.
package fft_arith_pkg;

  localparam int unsigned DIV_N = 17;
  localparam int unsigned DIV_M = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Quotient reported for divide-by-zero and for the single overflowing case.
  localparam logic [DIV_N-1:0] Q_SAT_POS = 17'h0FFFF;
  localparam logic [DIV_N-1:0] Q_SAT_NEG = 17'h10001;

endpackage

// File: rtl/N_bit_adder.sv
// Plain ripple-style N-bit adder with carry in and carry out.
module N_bit_adder #(
  parameter int unsigned N = 10
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};

endmodule

// File: rtl/divider_17_9bit.sv
// Signed restoring divider: one quotient bit per cycle on magnitudes, signs applied at the end.
module divider_17_9bit
  import fft_arith_pkg::*;
#(
  parameter int unsigned N = DIV_N,
  parameter int unsigned M = DIV_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         data_valid,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int unsigned CW = $clog2(N + 1);

  div_state_e     r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_quo_sh;
  logic [M-1:0]   r_rem;
  logic [M-1:0]   r_dvs_mag;
  logic           r_dvd_neg;
  logic           r_dvs_neg;
  logic           r_busy;
  logic           r_data_valid;
  logic [N-1:0]   r_quotient;
  logic [M-1:0]   r_remainder;
  logic           r_div_by_zero;
  logic           r_overflow;

  logic [M:0]     w_shift;
  logic [M:0]     w_neg_dvs;
  logic [M:0]     w_diff;
  logic           w_ge;
  logic           w_q_neg;
  logic           w_unused_diff_msb;

  // Partial remainder shifted left with the next dividend bit entering at the bottom.
  assign w_shift   = {r_rem, r_quo_sh[N-1]};
  assign w_neg_dvs = ~{1'b0, r_dvs_mag};
  assign w_q_neg   = r_dvd_neg ^ r_dvs_neg;

  // Carry out of shift + (-|divisor|) means the trial difference is non-negative.
  N_bit_adder #(
    .N (M + 1)
  ) u_trial_sub (
    .i_a    (w_shift),
    .i_b    (w_neg_dvs),
    .i_cin  (1'b1),
    .o_sum  (w_diff),
    .o_cout (w_ge)
  );

  // A kept difference is always below |divisor|, so its top bit is always zero.
  assign w_unused_diff_msb = w_diff[M];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_quo_sh      <= '0;
      r_rem         <= '0;
      r_dvs_mag     <= '0;
      r_dvd_neg     <= 1'b0;
      r_dvs_neg     <= 1'b0;
      r_busy        <= 1'b0;
      r_data_valid  <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd_neg <= dividend[N-1];
            r_dvs_neg <= divisor[M-1];
            r_quo_sh  <= dividend[N-1] ? N'(-dividend) : dividend;
            r_dvs_mag <= divisor[M-1] ? M'(-divisor) : divisor;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_rem    <= w_ge ? w_diff[M-1:0] : w_shift[M-1:0];
          r_quo_sh <= {r_quo_sh[N-2:0], w_ge};
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Only -2^(N-1) / -1 yields a positive magnitude with the top bit set.
          if (r_dvs_mag == '0) begin
            r_div_by_zero <= 1'b1;
            r_overflow    <= 1'b0;
            r_quotient    <= r_dvd_neg ? N'(Q_SAT_NEG) : N'(Q_SAT_POS);
            r_remainder   <= '0;
          end else if (!w_q_neg && r_quo_sh[N-1]) begin
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b1;
            r_quotient    <= N'(Q_SAT_POS);
            r_remainder   <= '0;
          end else begin
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
            r_quotient    <= w_q_neg ? N'(-r_quo_sh) : r_quo_sh;
            r_remainder   <= r_dvd_neg ? M'(-r_rem) : r_rem;
          end
          r_data_valid <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign data_valid  = r_data_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule
